// File: rtl/mips_mdu_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op codes, FSM states
// and the default datapath width.
package mips_mdu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_e;

  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_move(input logic [2:0] op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mips_mdu_step.sv
// One radix-2 iteration on magnitudes: shift-add multiply step or restoring
// divide step over the {acc_hi, acc_lo} accumulator pair.
module mips_mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc_hi} + {1'b0, operand};
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    next_hi = acc_hi;
    next_lo = acc_lo;
    if (is_div) begin
      // Partial remainder stays below the divisor, so diff[WIDTH] is a clean borrow flag.
      if (!diff[WIDTH]) begin
        next_hi = diff[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        next_hi = shifted[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_lo[0]) begin
        {next_hi, next_lo} = {sum, acc_lo[WIDTH-1:1]};
      end else begin
        {next_hi, next_lo} = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mips_mdu.sv
// Iterative MIPS HI/LO multiply/divide unit: one radix-2 step per enabled
// cycle, sign fix-up on the way out, optional single-cycle MTHI/MTLO.
module mips_mdu
  import mips_mdu_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MTX_BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state;
  state_e             next_state;
  logic [CW-1:0]      count;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   rs_q;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   operand;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;

  logic               accept;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  mips_mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_is_div(op_q)),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (operand),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  always_comb begin
    accept      = enable && start && (state == IDLE);
    rs_neg      = op_is_signed(op) && rs_val[WIDTH-1];
    rt_neg      = op_is_signed(op) && rt_val[WIDTH-1];
    rs_mag      = rs_neg ? -rs_val : rs_val;
    rt_mag      = rt_neg ? -rt_val : rt_val;
    product     = {acc_hi, acc_lo};
    product_fix = neg_q ? -product : product;
    // Most-negative / -1 needs no special case: the magnitude quotient already
    // equals the most-negative pattern and the remainder is zero.
    quo_fix     = div_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
    rem_fix     = div_zero ? rs_q : (neg_r ? -acc_hi : acc_hi);
    busy        = (state != IDLE);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept && op_is_arith(op)) begin
          next_state = CALC;
        end else if (accept && op_is_move(op) && (MTX_BYPASS == 0)) begin
          next_state = FINISH;
        end
      end
      CALC:    if (enable && (count == CW'(1))) next_state = FINISH;
      FINISH:  if (enable) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      op_q     <= '0;
      rs_q     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      operand  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else if (enable) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && op_is_arith(op)) begin
            op_q     <= op;
            rs_q     <= rs_val;
            count    <= CW'(WIDTH);
            neg_q    <= rs_neg ^ rt_neg;
            neg_r    <= rs_neg;
            div_zero <= (rt_val == '0);
            acc_hi   <= '0;
            acc_lo   <= op_is_div(op) ? rs_mag : rt_mag;
            operand  <= op_is_div(op) ? rt_mag : rs_mag;
          end else if (start && op_is_move(op)) begin
            if (MTX_BYPASS != 0) begin
              if (op == OP_MTHI) hi <= rs_val;
              else               lo <= rs_val;
              done <= 1'b1;
            end else begin
              op_q <= op;
              rs_q <= rs_val;
            end
          end
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count - CW'(1);
        end
        FINISH: begin
          done <= 1'b1;
          case (op_q)
            OP_MULT, OP_MULTU: {hi, lo} <= product_fix;
            OP_DIV, OP_DIVU: begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
            OP_MTHI: hi <= rs_q;
            OP_MTLO: lo <= rs_q;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mips_mdu.md
MIPS_MDU -- requirements
Module: mips_mdu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/HI/LO width (even, 8..64).
REQ-002 Parameter: MTX_BYPASS, default 1; 1 = MTHI/MTLO complete in one cycle without entering CALC.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 enable  input  1  global stall; when 0, all state, counters and outputs hold.
REQ-006 start  input  1  request strobe, sampled on rising edges with enable=1.
REQ-007 op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-008 rs_val  input  WIDTH  operand A (multiplicand, dividend, or MTHI/MTLO data).
REQ-009 rt_val  input  WIDTH  operand B (multiplier or divisor).
REQ-010 hi  output  WIDTH  HI register (product upper half or remainder).
REQ-011 lo  output  WIDTH  LO register (product lower half or quotient).
REQ-012 busy  output  1  operation in progress; new starts are ignored.
REQ-013 done  output  1  one-cycle pulse; hi/lo are updated in this cycle.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and FINISH.
REQ-015 In IDLE with enable=1 and start=1, a MULT/MULTU/DIV/DIVU op SHALL latch the operands, load counter=WIDTH and enter CALC.
REQ-016 In CALC, each enabled edge SHALL perform one radix-2 step (shift-add multiply, restoring divide), decrement the counter, and enter FINISH when the counter reaches 0.
REQ-017 FINISH SHALL apply sign correction, write hi/lo, pulse done for one cycle, and return to IDLE.
REQ-018 Latency: for a start accepted at edge k, done=1 and new hi/lo SHALL be visible after edge k+WIDTH+1, given no stall.
REQ-019 Each enable=0 cycle SHALL extend the latency by exactly one cycle.
REQ-020 busy SHALL be 1 from after the accept edge until the FINISH edge; it falls in the same cycle that done rises.
REQ-021 Signed ops SHALL operate on magnitudes; the product/quotient is negated when the operand signs differ, and the remainder takes the dividend's sign.
REQ-022 MULT/MULTU SHALL produce the 2*WIDTH-bit product with {hi,lo} = product.
REQ-023 DIV/DIVU SHALL produce lo = quotient and hi = remainder.
REQ-024 Divide by zero SHALL keep full latency and return lo = all ones, hi = rs_val.
REQ-025 Signed overflow (most-negative / -1) SHALL return lo = most-negative, hi = 0.
REQ-026 MTHI/MTLO with MTX_BYPASS=1 SHALL write hi/lo on the accept edge and pulse done the next cycle; busy stays 0.
REQ-027 With MTX_BYPASS=0, MTHI/MTLO SHALL enter FINISH directly (latency 1).
REQ-028 start while busy=1 SHALL be ignored, with no effect on state or operands.
REQ-029 An undefined op code SHALL be ignored in IDLE.
REQ-030 hi/lo SHALL change only on a FINISH edge or an MTHI/MTLO write; intermediate values SHALL never be visible on hi/lo.

Reset
REQ-031 reset=1 SHALL force FSM=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, and clear all operand registers, regardless of clk or enable.
REQ-032 reset mid-operation SHALL abort the operation; the first start after reset deasserts SHALL begin a fresh operation.

Structure
REQ-033 Package mips_mdu_pkg SHALL hold the op-code encodings, the FSM state enum and the default WIDTH constant.
REQ-034 The radix-2 step (add/subtract, shift) SHALL be one combinational sub-module, mips_mdu_step, parametrised by WIDTH.
REQ-035 The negate/sign-fix logic SHALL stay in mips_mdu.

Verification (WIDTH=32)
REQ-036 MULT rs=0xFFFFFFFD (-3), rt=5 -> done after 33 edges; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-037 DIVU 100/7 -> lo=14, hi=2.
REQ-038 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-039 DIV x/0 with rs=0x12345678 -> lo=0xFFFFFFFF, hi=0x12345678.
REQ-040 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-041 MULTU 0xFFFFFFFF*0xFFFFFFFF with enable low for 3 mid-CALC cycles -> done after 36 edges; hi=0xFFFFFFFE, lo=0x00000001.
REQ-042 Second start while busy -> ignored; result matches the first op only.
REQ-043 reset asserted at CALC cycle 10 -> busy=0, hi=lo=0 immediately, and no done pulse follows.
